// File: rtl/iobuf_pkg.sv
// ---------------------------------------------------------------------------
// iobuf_pkg
// Shared definitions for the IOBUF pad-control bank: the per-channel direction
// state type, the two-bit pad drive codes and a helper that sizes counters.
// Pad code bit order is {n_DRV_HIGH, DRV_LOW}; the code 2'b01 is never
// produced because it would drive high and low at the same time.
// ---------------------------------------------------------------------------
package iobuf_pkg;

   // Direction state of one channel. Only ST_OUT actually drives the pad.
   typedef enum logic [1:0] {
      ST_IN       = 2'd0,
      ST_WAIT_OUT = 2'd1,
      ST_OUT      = 2'd2,
      ST_WAIT_IN  = 2'd3
   } chanState_t;

   // {n_DRV_HIGH, DRV_LOW}
   typedef logic [1:0] padCode_t;

   localparam padCode_t PAD_HIGH    = 2'b00;
   localparam padCode_t PAD_LOW     = 2'b11;
   localparam padCode_t PAD_RELEASE = 2'b10;

   // Number of bits needed to hold values 0..maxVal (at least one bit).
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
   endfunction

   // Pad code for a channel that is (or is not) driving the given level.
   function automatic padCode_t padEncode(input logic drive, input logic level);
      if (!drive) begin
         return PAD_RELEASE;
      end
      return level ? PAD_HIGH : PAD_LOW;
   endfunction

endpackage

// File: rtl/iobuf_chan.sv
// ---------------------------------------------------------------------------
// iobuf_chan
// One bidirectional pad channel: direction-turnaround FSM, registered pad
// drive / pull-up control, 2-flop input synchronizer and input filter.
//
// Parameters:
//   TURNAROUND  hold-off cycles (0..15) on each direction change
//   FILTER_LEN  stable cycles (1..255) needed to accept an input change
// Ports:
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   DOUT, OE, PU_EN     core data, drive request, pull-up request
//   n_INPUT             inverted pad level, asynchronous
//   DIN, DIN_CHG        accepted input level and its 1-cycle change strobe
//   DIR_OUT             channel is actually driving
//   n_DRV_HIGH, DRV_LOW pad drive controls (registered)
//   n_ENA_PU            pad pull-up enable, active low (registered)
//
// Build option: define IOBUF_BANK_FILTER_EN to include the FILTER_LEN glitch
// filter. Without it the accepted level is simply the synchronizer output
// registered once and FILTER_LEN has no effect.
// ---------------------------------------------------------------------------
module iobuf_chan
   import iobuf_pkg::*;
#(
   parameter int TURNAROUND = 1,
   parameter int FILTER_LEN = 3
) (
   input  logic CLK,
   input  logic RESET,
   input  logic DOUT,
   input  logic OE,
   input  logic PU_EN,
   input  logic n_INPUT,
   output logic DIN,
   output logic DIN_CHG,
   output logic DIR_OUT,
   output logic n_DRV_HIGH,
   output logic DRV_LOW,
   output logic n_ENA_PU
);

   localparam int TW = cntWidth(TURNAROUND);
   localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND);

`ifdef IOBUF_BANK_FILTER_EN
   localparam bit FILTER_ON = 1'b1;
`else
   localparam bit FILTER_ON = 1'b0;
`endif

   // With the filter compiled out an input change is accepted after a
   // single cycle, which is exactly the register-once path below.
   localparam int ACCEPT_LEN = FILTER_ON ? FILTER_LEN : 1;

   chanState_t    state_q, state_d;
   logic [TW-1:0] turnCnt_q, turnCnt_d;
   padCode_t      padCode_q, padCode_d;
   logic          nEnaPu_q, nEnaPu_d;
   logic [1:0]    sync_q;
   logic          din_q, din_d;
   logic          dinChg_q, dinChg_d;
   logic          syncOut;
   logic          freeze;

   assign syncOut = sync_q[1];
   // While turning back to input the pad is still settling from our own
   // drive, so the accepted input level must not move.
   assign freeze  = (state_q == ST_WAIT_IN);

   // Direction state machine next-state logic. The turnaround counter only
   // matters in the two WAIT states; it counts down to zero and the state
   // moves on the edge after it reaches zero. Dropping OE while waiting to
   // drive abandons the turnaround at once since nothing was driven yet.
   always_comb begin
      state_d   = state_q;
      turnCnt_d = turnCnt_q;
      unique case (state_q)
         ST_IN: begin
            if (OE) begin
               if (TURNAROUND == 0) begin
                  state_d = ST_OUT;
               end else begin
                  state_d   = ST_WAIT_OUT;
                  turnCnt_d = TURN_LOAD;
               end
            end
         end
         ST_WAIT_OUT: begin
            if (!OE) begin
               state_d   = ST_IN;
               turnCnt_d = '0;
            end else if (turnCnt_q == '0) begin
               state_d = ST_OUT;
            end else begin
               turnCnt_d = turnCnt_q - TW'(1);
            end
         end
         ST_OUT: begin
            if (!OE) begin
               if (TURNAROUND == 0) begin
                  state_d = ST_IN;
               end else begin
                  state_d   = ST_WAIT_IN;
                  turnCnt_d = TURN_LOAD;
               end
            end
         end
         ST_WAIT_IN: begin
            if (OE) begin
               state_d   = ST_WAIT_OUT;
               turnCnt_d = TURN_LOAD;
            end else if (turnCnt_q == '0) begin
               state_d = ST_IN;
            end else begin
               turnCnt_d = turnCnt_q - TW'(1);
            end
         end
         default: begin
            state_d   = ST_IN;
            turnCnt_d = '0;
         end
      endcase
   end

   // Pad controls are computed from the next state so that drive, release
   // and pull-up all change on the same edge as the state itself, and the
   // driven level follows DOUT with one cycle of latency.
   always_comb begin
      padCode_d = padEncode(state_d == ST_OUT, DOUT);
      nEnaPu_d  = ~(PU_EN & (state_d != ST_OUT));
   end

   // Input acceptance. The counting filter is only built when more than one
   // stable cycle is required; a one-cycle acceptance is a plain register.
   if (ACCEPT_LEN > 1) begin : gFilter
      localparam int FW = cntWidth(ACCEPT_LEN);
      localparam logic [FW-1:0] FILT_LAST = FW'(ACCEPT_LEN - 1);

      logic [FW-1:0] filtCnt_q, filtCnt_d;

      // Count consecutive cycles where the synchronized level disagrees with
      // the accepted one; the change is taken on the edge that would make
      // the count reach the required length.
      always_comb begin
         din_d     = din_q;
         dinChg_d  = 1'b0;
         filtCnt_d = filtCnt_q;
         if (freeze || (syncOut == din_q)) begin
            filtCnt_d = '0;
         end else if (filtCnt_q == FILT_LAST) begin
            din_d     = syncOut;
            dinChg_d  = 1'b1;
            filtCnt_d = '0;
         end else begin
            filtCnt_d = filtCnt_q + FW'(1);
         end
      end

      // Filter counter register.
      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            filtCnt_q <= '0;
         end else begin
            filtCnt_q <= filtCnt_d;
         end
      end
   end else begin : gDirect
      // Accepted level simply follows the synchronizer one cycle later.
      always_comb begin
         din_d    = freeze ? din_q : syncOut;
         dinChg_d = ~freeze & (syncOut != din_q);
      end
   end

   // All channel state and registered outputs. Reset releases the pad and
   // disables the pull-up immediately, independent of the clock.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_IN;
         turnCnt_q <= '0;
         padCode_q <= PAD_RELEASE;
         nEnaPu_q  <= 1'b1;
         sync_q    <= 2'b11;
         din_q     <= 1'b1;
         dinChg_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         turnCnt_q <= turnCnt_d;
         padCode_q <= padCode_d;
         nEnaPu_q  <= nEnaPu_d;
         sync_q    <= {sync_q[0], ~n_INPUT};
         din_q     <= din_d;
         dinChg_q  <= dinChg_d;
      end
   end

   assign {n_DRV_HIGH, DRV_LOW} = padCode_q;
   assign n_ENA_PU              = nEnaPu_q;
   assign DIR_OUT               = (state_q == ST_OUT);
   assign DIN                   = din_q;
   assign DIN_CHG               = dinChg_q;

endmodule

// File: rtl/iobuf_bank.sv
// ---------------------------------------------------------------------------
// iobuf_bank
// Bank of WIDTH independent bidirectional pad channels between core logic
// and IOBUF-class pad cells. Each bit of every port belongs to one channel.
//
// Parameters:
//   WIDTH       number of channels
//   TURNAROUND  hold-off cycles (0..15) on each direction change
//   FILTER_LEN  stable cycles (1..255) needed to accept an input change
// Ports:
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   DOUT, OE, PU_EN     core data, drive requests, pull-up requests
//   DIN, DIN_CHG        accepted input levels and change strobes
//   DIR_OUT             channels actually driving
//   n_DRV_HIGH, DRV_LOW pad drive controls
//   n_ENA_PU            pad pull-up enables, active low
//   n_INPUT             inverted pad levels, asynchronous
//
// Build option: IOBUF_BANK_FILTER_EN enables the FILTER_LEN input filter.
// ---------------------------------------------------------------------------
module iobuf_bank #(
   parameter int WIDTH      = 8,
   parameter int TURNAROUND = 1,
   parameter int FILTER_LEN = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DOUT,
   input  logic [WIDTH-1:0] OE,
   input  logic [WIDTH-1:0] PU_EN,
   output logic [WIDTH-1:0] DIN,
   output logic [WIDTH-1:0] DIN_CHG,
   output logic [WIDTH-1:0] DIR_OUT,
   output logic [WIDTH-1:0] n_DRV_HIGH,
   output logic [WIDTH-1:0] DRV_LOW,
   output logic [WIDTH-1:0] n_ENA_PU,
   input  logic [WIDTH-1:0] n_INPUT
);

   // One self-contained channel per pin; channels share only clock/reset.
   for (genvar g = 0; g < WIDTH; g++) begin : gChan
      iobuf_chan #(
         .TURNAROUND (TURNAROUND),
         .FILTER_LEN (FILTER_LEN)
      ) uChan (
         .CLK        (CLK),
         .RESET      (RESET),
         .DOUT       (DOUT[g]),
         .OE         (OE[g]),
         .PU_EN      (PU_EN[g]),
         .n_INPUT    (n_INPUT[g]),
         .DIN        (DIN[g]),
         .DIN_CHG    (DIN_CHG[g]),
         .DIR_OUT    (DIR_OUT[g]),
         .n_DRV_HIGH (n_DRV_HIGH[g]),
         .DRV_LOW    (DRV_LOW[g]),
         .n_ENA_PU   (n_ENA_PU[g])
      );
   end

endmodule
